// File: rtl/main_mem_timed.sv
// main_mem_timed: clocked main-memory model sitting below the data cache.
// Serves whole-block reads and writes, one request at a time, with a fixed
// access latency and a one-cycle completion pulse.
//
// Ports:
//   clk, reset            clock / asynchronous active-high reset
//   req_valid/req_ready   request handshake (accepted when both high on an edge)
//   req_write             1 = write block, 0 = read block
//   req_addr              byte address; only the block-index bits are used
//   req_wdata             write block, word 0 in the LSBs
//   resp_valid            one-cycle completion pulse (reads and writes)
//   resp_rdata            last block read, word 0 in the LSBs
//   busy                  request in flight
module main_mem_timed #(
    parameter int WORD_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_BLOCKS      = 64,
    parameter int ADDR_WIDTH      = 10,
    parameter int LATENCY         = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  req_valid,
    input  logic                                  req_write,
    input  logic [ADDR_WIDTH-1:0]                 req_addr,
    input  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] req_wdata,
    output logic                                  req_ready,
    output logic                                  resp_valid,
    output logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] resp_rdata,
    output logic                                  busy
);
    localparam int BLK_W     = WORD_WIDTH * WORDS_PER_BLOCK;
    localparam int OFF       = $clog2(BLK_W / 8);
    localparam int IDX       = $clog2(NUM_BLOCKS);
    localparam int NUM_WORDS = NUM_BLOCKS * WORDS_PER_BLOCK;
    localparam int WA        = $clog2(NUM_WORDS);
    localparam int CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] mem_t;

    // Power-up content: word i holds the value i.
    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < NUM_WORDS; i++) m[i] = WORD_WIDTH'(i);
        return m;
    endfunction

    // Array contents survive reset, so the array has no reset branch.
    mem_t mem_q = init_mem();

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [IDX-1:0]   idx_q, idx_d;
    logic [BLK_W-1:0] wdata_q, wdata_d;
    logic [BLK_W-1:0] rdata_q, rdata_d;
    logic [WA-1:0]    base;
    logic             commit;

    // Only the block-index field of the address matters; offset and upper
    // bits are don't-care (upper bits give modulo-NUM_BLOCKS wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr;

    assign base   = WA'(idx_q) << $clog2(WORDS_PER_BLOCK);
    assign commit = (state_q == S_BUSY) && (cnt_q == '0) && write_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_BUSY;
                    write_d = req_write;
                    idx_d   = req_addr[OFF+IDX-1:OFF];
                    wdata_d = req_wdata;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Writes leave resp_rdata untouched.
                    if (!write_q) rdata_d = mem_q[base +: WORDS_PER_BLOCK];
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Reset clears state_q asynchronously, so an abandoned write never
    // reaches its commit edge.
    always_ff @(posedge clk) begin
        if (commit) mem_q[base +: WORDS_PER_BLOCK] <= wdata_q;
    end

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign busy       = (state_q == S_BUSY);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;

endmodule
